// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter.
//   arb_state_t : arbiter FSM state (IDLE, OWNED)
//   rr_pick_t   : result of a round-robin search (valid flag + winner index)
//   idx_width() : index width for a given controller count ($clog2, min 1)
//   rr_next()   : round-robin search over up to MAX_CTRL requesters
package wb_arb_pkg;

  localparam int MAX_CTRL  = 16;
  localparam int MAX_IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Search starts at last+1 and wraps modulo n; 'last' itself is visited
  // at the very end, so a previous owner that re-requests gets the lowest
  // priority. Bits set in 'exclude' never win.
  function automatic rr_pick_t rr_next(input logic [MAX_CTRL-1:0]  req,
                                       input logic [MAX_IDX_W-1:0] last,
                                       input logic [MAX_CTRL-1:0]  exclude,
                                       input int                   n);
    rr_pick_t             r;
    logic [MAX_CTRL-1:0]  m;
    int                   c;
    r = '0;
    m = req & ~exclude;
    for (int i = 1; i <= MAX_CTRL; i++) begin
      if (i <= n) begin
        c = (int'(last) + i) % n;
        if (!r.valid && m[c[MAX_IDX_W-1:0]]) begin
          r.valid = 1'b1;
          r.idx   = c[MAX_IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_pick.sv
// Purely combinational round-robin priority picker.
//   req_i   : request vector
//   last_i  : index of the most recent winner (search starts just after it)
//   excl_i  : requesters that may not win this time
//   grant_o : one-hot winner (zero when nothing eligible)
//   idx_o   : winner index
//   valid_o : a winner exists
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int NUM_CTRL = 4,
  parameter int IDX_W    = idx_width(NUM_CTRL)
) (
  input  logic [NUM_CTRL-1:0] req_i,
  input  logic [IDX_W-1:0]    last_i,
  input  logic [NUM_CTRL-1:0] excl_i,
  output logic [NUM_CTRL-1:0] grant_o,
  output logic [IDX_W-1:0]    idx_o,
  output logic                valid_o
);

  logic [MAX_CTRL-1:0]  req_w;
  logic [MAX_CTRL-1:0]  excl_w;
  logic [MAX_IDX_W-1:0] last_w;
  rr_pick_t             pick;
  logic                 unused_idx_hi;

  always_comb begin
    req_w                  = '0;
    excl_w                 = '0;
    last_w                 = '0;
    req_w[NUM_CTRL-1:0]    = req_i;
    excl_w[NUM_CTRL-1:0]   = excl_i;
    last_w[IDX_W-1:0]      = last_i;
    pick                   = rr_next(req_w, last_w, excl_w, NUM_CTRL);
    valid_o                = pick.valid;
    idx_o                  = pick.idx[IDX_W-1:0];
    grant_o                = '0;
    if (pick.valid) grant_o[idx_o] = 1'b1;
  end

  // Upper index bits are always zero for small NUM_CTRL.
  assign unused_idx_hi = ^pick.idx;

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic device port between
// NUM_CTRL upstream controllers. The owner keeps the bus until it drops cyc;
// handoff to the next requester has no idle cycle.
//   clk_i, rst_i             : clock, synchronous active-high reset
//   ctrl_cyc_i/stb_i/dat_i   : per-controller request (dat packed k*DW +: DW)
//   ctrl_ack_o / ctrl_stall_o: ack to owner only; non-owners see stall=cyc
//   dev_cyc_o/stb_o/dat_o    : routed owner request to the device
//   dev_ack_i / dev_stall_i  : device response
//   grant_o                  : registered one-hot owner, zero when idle
//   timeout_o                : watchdog revoke pulse (WB_ARB_TIMEOUT_EN only)
// Optional feature macro: WB_ARB_TIMEOUT_EN (watchdog on stalled owners).
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_CTRL   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_CTRL-1:0]            ctrl_cyc_i,
  input  logic [NUM_CTRL-1:0]            ctrl_stb_i,
  input  logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_dat_i,
  output logic [NUM_CTRL-1:0]            ctrl_ack_o,
  output logic [NUM_CTRL-1:0]            ctrl_stall_o,
  output logic                           dev_cyc_o,
  output logic                           dev_stb_o,
  output logic [DATA_WIDTH-1:0]          dev_dat_o,
  input  logic                           dev_ack_i,
  input  logic                           dev_stall_i,
  output logic [NUM_CTRL-1:0]            grant_o
`ifdef WB_ARB_TIMEOUT_EN
  ,
  output logic                           timeout_o
`endif
);

  localparam int IDX_W = idx_width(NUM_CTRL);

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     last_q,  last_d;
  logic [NUM_CTRL-1:0]  grant_q, grant_d;

  logic [NUM_CTRL-1:0]  pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_vld;
  logic [IDX_W-1:0]     pick_last;
  logic                 owner_cyc;
  logic                 owned_act;
  logic                 wd_hit;

  assign owner_cyc = ctrl_cyc_i[owner_q];

  // While owned, the search starts after the current owner and excludes it
  // (grant_q is its one-hot); in IDLE grant_q is zero so nothing is excluded.
  assign pick_last = (state_q == OWNED) ? owner_q : last_q;

  wb_rr_pick #(
    .NUM_CTRL (NUM_CTRL),
    .IDX_W    (IDX_W)
  ) u_pick (
    .req_i   (ctrl_cyc_i),
    .last_i  (pick_last),
    .excl_i  (grant_q),
    .grant_o (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 7) ? $clog2(TIMEOUT + 1) : 7;

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

  // The revoke cycle is the one in which the count has reached TIMEOUT.
  assign wd_hit    = (state_q == OWNED) && (wd_cnt_q >= CNT_W'(TIMEOUT));
  assign timeout_o = wd_hit;

  // Counts owned cycles with a strobe waiting for ack; any ack, cyc drop,
  // revoke or idle period starts it over.
  always_comb begin
    wd_cnt_d = '0;
    if (state_q == OWNED && !wd_hit && owner_cyc && dev_stb_o && !dev_ack_i)
      wd_cnt_d = wd_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) wd_cnt_q <= '0;
    else       wd_cnt_q <= wd_cnt_d;
  end
`else
  logic unused_timeout;
  assign wd_hit         = 1'b0;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // Routing is suppressed during reset so no ack leaks through, and during
  // the revoke cycle so the device never sees the revoked controller again.
  assign owned_act = (state_q == OWNED) && !rst_i && !wd_hit;

  always_comb begin
    dev_cyc_o    = 1'b0;
    dev_stb_o    = 1'b0;
    dev_dat_o    = '0;
    ctrl_ack_o   = '0;
    ctrl_stall_o = ctrl_cyc_i;
    if (owned_act) begin
      dev_cyc_o             = owner_cyc;
      dev_stb_o             = ctrl_stb_i[owner_q];
      dev_dat_o             = ctrl_dat_i[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
      ctrl_ack_o[owner_q]   = dev_ack_i;
      ctrl_stall_o[owner_q] = dev_stall_i;
    end
    if (wd_hit) ctrl_stall_o[owner_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = OWNED;
          owner_d = pick_idx;
          grant_d = pick_gnt;
        end
      end
      OWNED: begin
        if (wd_hit) begin
          state_d = IDLE;
          last_d  = owner_q;
          grant_d = '0;
        end else if (!owner_cyc) begin
          last_d = owner_q;
          if (pick_vld) begin
            owner_d = pick_idx;
            grant_d = pick_gnt;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // last resets to NUM_CTRL-1 so controller 0 is first in line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_CTRL - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  assign grant_o = grant_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed testbench for wb_rr_arbiter (NUM_CTRL=4, DATA_WIDTH=8, TIMEOUT=8).
// Inputs change 1 time unit after the rising edge; outputs are checked 2
// units later, well before the next edge.
module tb_wb_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cyc, stb;
  logic [31:0] dat;
  logic [3:0]  ack, stall, grant;
  logic        dev_cyc, dev_stb, dev_ack, dev_stall;
  logic [7:0]  dev_dat;
`ifdef WB_ARB_TIMEOUT_EN
  logic        tmo;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(
    .NUM_CTRL   (4),
    .DATA_WIDTH (8),
    .TIMEOUT    (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ctrl_cyc_i   (cyc),
    .ctrl_stb_i   (stb),
    .ctrl_dat_i   (dat),
    .ctrl_ack_o   (ack),
    .ctrl_stall_o (stall),
    .dev_cyc_o    (dev_cyc),
    .dev_stb_o    (dev_stb),
    .dev_dat_o    (dev_dat),
    .dev_ack_i    (dev_ack),
    .dev_stall_i  (dev_stall),
    .grant_o      (grant)
`ifdef WB_ARB_TIMEOUT_EN
    ,
    .timeout_o    (tmo)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int         order   [5] = '{0, 1, 2, 3, 0};
  logic [7:0] exp_dat [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

  initial begin
    rst = 1'b1; cyc = '0; stb = '0; dat = '0; dev_ack = 1'b0; dev_stall = 1'b0;
    tick(); tick();

    // reset: requesters stall, bus idle
    cyc = 4'b0011; settle();
    chk("rst_stall",   stall,   4'b0011);
    chk("rst_dev_cyc", dev_cyc, 1'b0);
    chk("rst_grant",   grant,   4'b0000);
    chk("rst_ack",     ack,     4'b0000);
    cyc = '0; rst = 1'b0; tick();

    // single requester, one-cycle grant latency
    cyc = 4'b0001; stb = 4'b0001; dat = 32'h0000_00A5; settle();
    chk("sr_c0_dev_cyc", dev_cyc, 1'b0);
    chk("sr_c0_stall",   stall,   4'b0001);
    tick();
    chk("sr_c1_dev_cyc", dev_cyc, 1'b1);
    chk("sr_c1_dev_stb", dev_stb, 1'b1);
    chk("sr_c1_dev_dat", dev_dat, 8'hA5);
    chk("sr_c1_grant",   grant,   4'b0001);
    chk("sr_c1_stall",   stall,   4'b0000);
    tick();
    dev_ack = 1'b1; settle();
    chk("sr_c2_ack", ack, 4'b0001);
    tick();
    dev_ack = 1'b0; cyc = '0; stb = '0; settle();
    chk("sr_c3_ack", ack, 4'b0000);
    tick();
    chk("sr_idle_grant", grant, 4'b0000);

    // fairness: all four request, each drops after its ack
    rst = 1'b1; tick(); rst = 1'b0;
    cyc = 4'hF; stb = 4'hF; dat = 32'h4433_2211; tick();
    for (int i = 0; i < 5; i++) begin
      chk("fair_grant",   grant,   32'(1) << order[i]);
      chk("fair_dev_cyc", dev_cyc, 1'b1);
      chk("fair_dev_dat", dev_dat, exp_dat[i]);
      dev_ack = 1'b1; settle();
      chk("fair_ack", ack, 32'(1) << order[i]);
      tick();
      dev_ack = 1'b0; cyc[order[i]] = 1'b0; settle();
      chk("fair_drop_dev_cyc", dev_cyc, 1'b0);
      tick();
      cyc[order[i]] = 1'b1;
    end

    // contention: owner 1 on the bus, controller 3 waiting
    chk("cont_grant", grant, 4'b0010);
    cyc = 4'b1010; stb = 4'b1010; dev_stall = 1'b1; settle();
    chk("cont_stall_dev", stall, 4'b1010);
    chk("cont_ack_none",  ack,   4'b0000);
    dev_stall = 1'b0; settle();
    chk("cont_stall_nodev", stall, 4'b1000);
    dev_ack = 1'b1; settle();
    chk("cont_ack_owner", ack, 4'b0010);
    tick();
    dev_ack = 1'b0;

    // wrap: owner 1 drops -> 3, then 3 drops with 0 waiting -> 0
    cyc = 4'b1000; stb = 4'b1000; tick();
    chk("wrap_grant3", grant, 4'b1000);
    cyc = 4'b1001; stb = 4'b1001; settle();
    chk("wrap_stall", stall, 4'b0001);
    cyc = 4'b0001; tick();
    chk("wrap_grant0", grant, 4'b0001);

    // lone controller 3 re-request after drop: one idle cycle between
    cyc = 4'b0000; tick();
    chk("rereq_idle0", grant, 4'b0000);
    cyc = 4'b1000; tick();
    chk("rereq_grant_a", grant, 4'b1000);
    cyc = 4'b0000; tick();
    chk("rereq_idle1", grant, 4'b0000);
    cyc = 4'b1000; tick();
    chk("rereq_grant_b", grant, 4'b1000);

    // reset while owner 2 is stalled
    cyc = 4'b0100; stb = 4'b0100; tick();
    chk("rm_grant2", grant, 4'b0100);
    dev_stall = 1'b1; settle();
    chk("rm_stall", stall, 4'b0100);
    rst = 1'b1; dev_ack = 1'b1; settle();
    chk("rm_rst_dev_cyc", dev_cyc, 1'b0);
    chk("rm_rst_ack",     ack,     4'b0000);
    tick();
    rst = 1'b0; dev_ack = 1'b0; dev_stall = 1'b0; settle();
    chk("rm_post_grant",   grant,   4'b0000);
    chk("rm_post_dev_cyc", dev_cyc, 1'b0);
    cyc = 4'b0101; stb = 4'b0101; tick();
    chk("rm_first_grant", grant, 4'b0001);

    // ack with no owner is dropped
    cyc = '0; stb = '0; tick();
    dev_ack = 1'b1; settle();
    chk("idle_ack", ack, 4'b0000);
    chk("idle_dev_cyc", dev_cyc, 1'b0);
    dev_ack = 1'b0;

`ifdef WB_ARB_TIMEOUT_EN
    // watchdog: owner 0 strobes with no ack for TIMEOUT cycles
    rst = 1'b1; tick(); rst = 1'b0;
    cyc = 4'b0011; stb = 4'b0011; dat = 32'h0000_BBAA; tick();
    chk("wd_grant0", grant, 4'b0001);
    for (int i = 1; i < 8; i++) tick();
    chk("wd_pre", tmo, 1'b0);
    tick();
    chk("wd_pulse",   tmo,     1'b1);
    chk("wd_stall",   stall,   4'b0011);
    chk("wd_dev_cyc", dev_cyc, 1'b0);
    tick();
    chk("wd_pulse_end", tmo,   1'b0);
    chk("wd_idle",      grant, 4'b0000);
    tick();
    chk("wd_next_grant", grant, 4'b0010);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
